// File: rtl/mvau_thresh_act.sv
// Multi-threshold activation stage behind the MVAU stream unit.
// Optional output bias: define MVAU_ACT_BIAS_EN (adds ACT_BIAS).
module mvau_thresh_act #(
    parameter int PE    = 2,
    parameter int NF    = 2,
    parameter int TA    = 16,
    parameter int TOUT  = 2,
    parameter int NF_BW = (NF > 1) ? $clog2(NF) : 1,
    parameter int PE_BW = (PE > 1) ? $clog2(PE) : 1,
    parameter int NT_BW = TOUT
`ifdef MVAU_ACT_BIAS_EN
    ,
    parameter int ACT_BIAS = 0
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_v,
    input  logic [PE*TA-1:0]     in,
    input  logic                 thr_we,
    input  logic [NF_BW-1:0]     thr_nf,
    input  logic [PE_BW-1:0]     thr_pe,
    input  logic [NT_BW-1:0]     thr_idx,
    input  logic [TA-1:0]        thr_wdata,
    output logic                 out_v,
    output logic [PE*TOUT-1:0]   out
);

    localparam int NT = (1 << TOUT) - 1;

    logic [NF_BW-1:0]      nf_cnt_q, nf_cnt_d;
    logic                  s1_v_q, s1_v_d;
    logic [PE*TA-1:0]      s1_acc_q, s1_acc_d;
    logic [NF_BW-1:0]      s1_nf_q, s1_nf_d;
    logic                  out_v_q, out_v_d;
    logic [PE*TOUT-1:0]    out_q, out_d;
    logic [TA-1:0]         thr_q [NF][PE][NT];
    logic [TA-1:0]         thr_d [NF][PE][NT];
    logic                  thr_ok;
    logic [TOUT-1:0]       cnt [PE];
    logic [TA-1:0]         acc [PE];

    // Fold counter advances per accepted beat and wraps at NF-1.
    always_comb begin
        nf_cnt_d = nf_cnt_q;
        if (in_v) begin
            if (nf_cnt_q == NF_BW'(NF - 1)) begin
                nf_cnt_d = '0;
            end else begin
                nf_cnt_d = nf_cnt_q + NF_BW'(1);
            end
        end
    end

    // Stage 1 captures the beat and tags it with its fold.
    always_comb begin
        s1_v_d   = in_v;
        s1_acc_d = s1_acc_q;
        s1_nf_d  = s1_nf_q;
        if (in_v) begin
            s1_acc_d = in;
            s1_nf_d  = nf_cnt_q;
        end
    end

    // Threshold table write; out-of-range addresses are dropped.
    always_comb begin
        thr_d  = thr_q;
        thr_ok = (int'(thr_nf) < NF) && (int'(thr_pe) < PE)
                 && (int'(thr_idx) < NT);
        if (thr_we && thr_ok) begin
            thr_d[thr_nf][thr_pe][thr_idx] = thr_wdata;
        end
    end

    // Stage 2 counts thresholds met by each lane's accumulator.
    always_comb begin
        out_v_d = s1_v_q;
        out_d   = out_q;
        for (int p = 0; p < PE; p++) begin
            acc[p] = s1_acc_q[p*TA +: TA];
            cnt[p] = '0;
            for (int i = 0; i < NT; i++) begin
                if ($signed(acc[p]) >= $signed(thr_q[s1_nf_q][p][i])) begin
                    cnt[p] = cnt[p] + TOUT'(1);
                end
            end
            if (s1_v_q) begin
`ifdef MVAU_ACT_BIAS_EN
                out_d[p*TOUT +: TOUT] = cnt[p] + TOUT'(ACT_BIAS);
`else
                out_d[p*TOUT +: TOUT] = cnt[p];
`endif
            end
        end
    end

    // Pipeline and fold state, cleared on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nf_cnt_q <= '0;
            s1_v_q   <= 1'b0;
            s1_acc_q <= '0;
            s1_nf_q  <= '0;
            out_v_q  <= 1'b0;
            out_q    <= '0;
        end else begin
            nf_cnt_q <= nf_cnt_d;
            s1_v_q   <= s1_v_d;
            s1_acc_q <= s1_acc_d;
            s1_nf_q  <= s1_nf_d;
            out_v_q  <= out_v_d;
            out_q    <= out_d;
        end
    end

    // Threshold storage keeps its contents across reset.
    always_ff @(posedge clk) begin
        thr_q <= thr_d;
    end

    assign out_v = out_v_q;
    assign out   = out_q;

endmodule

// File: tb/tb_mvau_thresh_act.sv
// Randomized self-checking bench for mvau_thresh_act.
// Honours MVAU_ACT_BIAS_EN (bias -2) when defined.
module tb_mvau_thresh_act;

    localparam int PE   = 2;
    localparam int NF   = 2;
    localparam int TA   = 16;
    localparam int TOUT = 2;
    localparam int NT   = (1 << TOUT) - 1;
`ifdef MVAU_ACT_BIAS_EN
    localparam int TB_BIAS = -2;
`else
    localparam int TB_BIAS = 0;
`endif

    logic                clk;
    logic                rst_n;
    logic                in_v;
    logic [PE*TA-1:0]    in_bus;
    logic                thr_we;
    logic [0:0]          thr_nf;
    logic [0:0]          thr_pe;
    logic [1:0]          thr_idx;
    logic [TA-1:0]       thr_wdata;
    logic                out_v;
    logic [PE*TOUT-1:0]  out_bus;

    mvau_thresh_act #(
        .PE(PE), .NF(NF), .TA(TA), .TOUT(TOUT)
`ifdef MVAU_ACT_BIAS_EN
        , .ACT_BIAS(TB_BIAS)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_v(in_v), .in(in_bus),
        .thr_we(thr_we), .thr_nf(thr_nf), .thr_pe(thr_pe),
        .thr_idx(thr_idx), .thr_wdata(thr_wdata),
        .out_v(out_v), .out(out_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference state
    int                 mthr [NF][PE][NT];
    int                 m_fold;
    bit                 prev_v;
    logic [PE*TOUT-1:0] prev_out;
    logic [PE*TOUT-1:0] last_out;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [PE*TOUT-1:0] model(input int f,
                                                 input int a0,
                                                 input int a1);
        logic [PE*TOUT-1:0] r;
        int a [PE];
        a[0] = a0;
        a[1] = a1;
        r = '0;
        for (int p = 0; p < PE; p++) begin
            int c;
            c = 0;
            for (int i = 0; i < NT; i++)
                if (a[p] >= mthr[f][p][i]) c++;
            c = (c + TB_BIAS) & ((1 << TOUT) - 1);
            r[p*TOUT +: TOUT] = c[TOUT-1:0];
        end
        return r;
    endfunction

    function automatic int sx(input logic [TA-1:0] v);
        return int'($signed(v));
    endfunction

    task automatic step(input bit v, input int a0, input int a1,
                        input bit we, input int wnf, input int wpe,
                        input int widx, input int wd);
        logic [PE*TOUT-1:0] cur;
        logic [PE*TOUT-1:0] hold;
        in_v      = v;
        in_bus    = {a1[TA-1:0], a0[TA-1:0]};
        thr_we    = we;
        thr_nf    = wnf[0:0];
        thr_pe    = wpe[0:0];
        thr_idx   = widx[1:0];
        thr_wdata = wd[TA-1:0];
        if (we && wnf < NF && wpe < PE && widx < NT)
            mthr[wnf][wpe][widx] = sx(wd[TA-1:0]);
        cur = '0;
        if (v) begin
            cur = model(m_fold, sx(a0[TA-1:0]), sx(a1[TA-1:0]));
            m_fold = (m_fold + 1) % NF;
        end
        @(posedge clk);
        #1;
        hold = prev_v ? prev_out : last_out;
        chk("out_v", 64'(out_v), 64'(prev_v));
        chk("out", 64'(out_bus), 64'(hold));
        last_out = hold;
        prev_v   = v;
        prev_out = cur;
    endtask

    task automatic wr(input int f, input int p, input int i, input int d);
        step(1'b0, 0, 0, 1'b1, f, p, i, d);
    endtask

    task automatic beat(input int a0, input int a1);
        step(1'b1, a0, a1, 1'b0, 0, 0, 0, 0);
    endtask

    task automatic idle();
        step(1'b0, 0, 0, 1'b0, 0, 0, 0, 0);
    endtask

    task automatic model_reset();
        m_fold   = 0;
        prev_v   = 1'b0;
        prev_out = '0;
        last_out = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        in_v = 1'b0;
        in_bus = '0;
        thr_we = 1'b0;
        thr_nf = '0;
        thr_pe = '0;
        thr_idx = '0;
        thr_wdata = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_v", 64'(out_v), 64'd0);
        chk("rst_out", 64'(out_bus), 64'd0);
        rst_n = 1'b1;

        // basic compare thresholds, fold 1 saturated
        wr(0, 0, 0, -10); wr(0, 0, 1, 0);   wr(0, 0, 2, 10);
        wr(0, 1, 0, 100); wr(0, 1, 1, 200); wr(0, 1, 2, 300);
        for (int p = 0; p < PE; p++)
            for (int i = 0; i < NT; i++) wr(1, p, i, 32'h7FFF);
        beat(5, 250);
        idle();
        idle();

        // fold wrap: align to fold 0 then four back-to-back beats
        if (m_fold != 0) beat(0, 0);
        for (int k = 0; k < 4; k++) beat(5, 0);
        idle();
        idle();

        // boundaries
        wr(0, 0, 0, -32768); wr(0, 0, 1, -32768); wr(0, 0, 2, 32767);
        if (m_fold != 0) beat(0, 0);
        beat(-32768, 0);
        beat(0, 0);
        wr(0, 0, 0, 10); wr(0, 0, 1, 10); wr(0, 0, 2, 10);
        beat(10, 0);
        beat(0, 0);

        // write / compare collision
        wr(0, 0, 0, -10); wr(0, 0, 1, 0); wr(0, 0, 2, 10);
        beat(5, 150);
        wr(0, 0, 2, 3);
        beat(0, 0);
        beat(5, 150);
        idle();
        idle();

        // out-of-range index write must be dropped
        wr(0, 0, 3, -32768);
        if (m_fold != 0) beat(0, 0);
        beat(5, 0);
        idle();
        idle();

        // randomized traffic with interleaved writes
        for (int n = 0; n < 400; n++) begin
            bit v, we;
            int a0, a1, wf, wp, wi, wd;
            v  = ($urandom_range(0, 3) != 0);
            we = ($urandom_range(0, 3) == 0);
            wf = $urandom_range(0, NF - 1);
            wp = $urandom_range(0, PE - 1);
            wi = $urandom_range(0, NT);
            wd = sx(16'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                a0 = sx(16'($urandom));
                a1 = sx(16'($urandom));
            end else begin
                a0 = mthr[m_fold][0][$urandom_range(0, NT - 1)]
                     + $urandom_range(0, 2) - 1;
                a1 = mthr[m_fold][1][$urandom_range(0, NT - 1)]
                     + $urandom_range(0, 2) - 1;
            end
            step(v, a0, a1, we, wf, wp, wi, wd);
        end

        // reset mid-stream
        beat(1000, -1000);
        beat(-5, 7);
        in_v = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_v", 64'(out_v), 64'd0);
        chk("arst_out", 64'(out_bus), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("arst_hold_v", 64'(out_v), 64'd0);
        rst_n = 1'b1;
        model_reset();
        beat(5, 150);
        beat(5, 150);
        beat(-20000, 20000);
        idle();
        idle();
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mvau_thresh_act.md
Name: mvau_thresh_act

Overview:
- Multi-threshold activation stage directly downstream of the MVAU stream unit.
- Fills the USE_ACT=1 slot: consumes PE signed accumulator lanes per valid beat and emits PE quantized activations.
- Each output is the count of per-channel thresholds the accumulator meets or exceeds.
- Thresholds are per output channel, selected by an internal neuron-fold counter, and loaded through a simple write port.

Parameters:
- PE, 2, accumulator lanes per beat (matches MVAU PE)
- NF, 2, neuron folds per output vector (MatrixH/PE)
- TA, 16, signed accumulator width per lane
- TOUT, 2, output bits per lane; thresholds per channel NT = 2**TOUT-1
- NF_BW, $clog2(NF) (min 1), fold counter / threshold fold address width
- PE_BW, $clog2(PE) (min 1), threshold lane address width
- NT_BW, TOUT, threshold index address width

Ports:
- clk  in  1  main clock
- rst_n  in  1  active-low reset
- in_v  in  1  accumulator beat valid
- in  in  PE*TA  accumulators; lane p at bits [p*TA +: TA], lane 0 at LSB
- thr_we  in  1  threshold write enable
- thr_nf  in  NF_BW  threshold write fold address
- thr_pe  in  PE_BW  threshold write lane address
- thr_idx  in  NT_BW  threshold index, 0..NT-1
- thr_wdata  in  TA  signed threshold value
- out_v  out  1  activation valid
- out  out  PE*TOUT  activations; lane p at bits [p*TOUT +: TOUT]

Interface decision (already decided):
- One clock; reset is asynchronous and active-low.
- Ports are named clk and rst_n.

Behaviour:
- Reset (async assert, sync release): out_v=0, out=0, fold counter nf_cnt=0, all pipeline valids 0.
- Threshold storage is not reset; contents are undefined until written.
- No backpressure; the block accepts every in_v beat.
- Fold counter:
  - Increments on each accepted beat (in_v=1).
  - Wraps NF-1 -> 0.
  - Holds when in_v=0.
  - Beat k of a vector uses the thresholds of fold (k mod NF).
- Pipeline, latency 2 cycles from in_v to out_v:
  - S1: register in and in_v; latch nf_cnt into the S1 fold tag.
  - S2: for each lane p, compute sum over i<NT of (signed(acc_p) >= signed(thr[fold][p][i])); register into out lane p and set out_v.
- The result range 0..NT fits TOUT bits exactly, so no saturation is needed.
- Thresholds need not be sorted; the result is always the count of satisfied comparisons.
- out and out_v update only from the pipeline. When out_v=0, out holds its last value.
- Back-to-back beats sustain one output per cycle.
- Threshold writes:
  - Synchronous, at the clk edge with thr_we=1.
  - A write is visible to S2 compares from the next cycle.
  - A write and a compare to the same entry in the same cycle: the compare uses the old value.
  - Out-of-range thr_nf/thr_pe/thr_idx (≥ NF/PE/NT) is ignored; no write occurs.
- Comparison rules:
  - acc == thr counts as met (>=).
  - Most-negative accumulator (−2**(TA-1)) compared against itself counts as met.
- Reset mid-operation: in-flight beats are discarded, nf_cnt returns to 0, out_v=0 next cycle.
  - The first beat after reset is treated as fold 0.
  - Threshold contents are retained.
- NF=1: nf_cnt stays 0 and fold 0 is used for every beat.

Optional Feature:
- Macro: MVAU_ACT_BIAS_EN.
- When defined:
  - Adds parameter ACT_BIAS (signed int, default 0).
  - Each lane outputs count + ACT_BIAS, truncated to TOUT bits (two's complement wrap).
  - Supports signed activation encodings, e.g. bias −2 with TOUT=2 maps counts 0..3 to −2..1.
  - Latency is unchanged.
- When undefined: the output is the raw unsigned count and the parameter does not exist.

Test Plan:
- Reset: hold rst_n=0 mid-stream with in_v=1 → out_v=0 and out=0 asynchronously; after release, first beat uses fold 0.
- Basic compare: thr[0][0]={−10,0,10}, thr[0][1]={100,200,300}; in lane0=5, lane1=250, in_v=1 → two cycles later out_v=1, lane0=2, lane1=2.
- Fold wrap: fold1 thresholds = {0x7FFF}x3 on both lanes; send 4 back-to-back beats with lane0=5 → outputs 2,0,2,0 on consecutive cycles.
- Boundaries: lane0 = −32768 with thresholds {−32768,−32768,32767} → 2; lane0=10 with threshold 10 at each index → 3.
- Write/read collision: overwrite thr[0][0][2] from 10 to 3 in the same cycle as a compare of value 5 → result 2; the next fold-0 beat with value 5 → 3.
- With MVAU_ACT_BIAS_EN and ACT_BIAS=−2: counts 0 and 3 → out lane = 2'b10 and 2'b01.
